ce_scheduler: RTL
=================

// Module: ce_scheduler
//
// PURPOSE
//   Runtime-programmable scheduler of clock-enable strobes for the FM receiver's multirate chain.
//   Replaces the per-stage fixed-ratio divided clocks with N_CH single-cycle enables on one clock.
//   Each channel has a programmable period and phase, so decimator/filter stages can be staggered.
//   New settings are accepted over a valid/ready port and take effect only at a period boundary,
//   so no strobe is ever shortened or doubled.
//
// PARAMETERS
//   N_CH   4    number of enable channels (>=1)
//   W      16   width of period, phase and internal counters
//
// PORTS
//   clk        in   1              system clock
//   reset      in   1              synchronous, active-high reset
//   enable     in   1              global run; 0 freezes all counters
//   cfg_valid  in   1              config request
//   cfg_ready  out  1              config slot free
//   cfg_ch     in   $clog2(N_CH)   target channel (use width 1 when N_CH==1)
//   cfg_div    in   W              period in cycles; 0 = channel disabled
//   cfg_phase  in   W              strobe offset within period
//   ce_o       out  N_CH           per-channel one-cycle enable strobes (registered)
//   phase_err  out  N_CH           sticky: active phase >= div
//
// BEHAVIOUR
//   - All logic is on posedge clk; there are no other clocks and no asynchronous paths.
//   - Reset (sync, high) forces:
//     - every div, phase and counter to 0, so all channels are disabled;
//     - ce_o = 0, phase_err = 0, pending slot empty, cfg_ready = 1.
//     - Reset asserted mid-operation discards any pending config.
//   - Config handshake
//     - cfg_ready = !pend_v. A transfer occurs on an edge with cfg_valid && cfg_ready.
//     - The transfer captures {ch, div, phase} into a single pending slot and sets pend_v.
//     - cfg_* inputs are ignored while cfg_ready = 0.
//   - Apply rule, evaluated every cycle while pend_v = 1, for target channel c:
//     - Apply if div[c] == 0, or if enable && cnt[c] == div[c]-1 (the period boundary).
//     - On the apply edge: div[c], phase[c] <= pending; cnt[c] <= 0; pend_v <= 0.
//     - On the apply edge: phase_err[c] <= (new div != 0 && new phase >= new div).
//     - cfg_ready returns high in the cycle after apply.
//     - A new transfer may be accepted on that cycle's edge.
//   - Counters, for each channel with div != 0 and enable = 1:
//     - cnt <= (cnt == div-1) ? 0 : cnt+1.
//     - When enable = 0, cnt holds.
//     - When div == 0, cnt holds at 0.
//   - Strobe
//     - ce_o[i] <= enable && div[i] != 0 && cnt[i] == phase[i].
//     - Result: one cycle high, once per div[i] enabled cycles.
//     - When phase >= div, the strobe never fires; phase_err flags this.
//     - div == 1 with phase == 0 holds ce_o high continuously.
//   - Latency
//     - Apply on edge A: the first ce_o high is after edge A+phase+1, provided enable stays 1.
//     - From a disabled channel, apply occurs on the edge after the handshake.
//   - Reprogramming a running channel
//     - The old period completes in full; the new period starts with cnt = 0.
//     - Writing div = 0 disables the channel at its boundary; ce_o drops on the following edge.
//   - Same-cycle handshake and apply are impossible: one slot; capture and apply are on separate edges.
//   - Reprogramming a disabled channel while enable = 0 is allowed; apply is not gated by enable.
//   - Counter arithmetic is W-bit unsigned; wrap is explicit at div-1, so no overflow is possible.
//
// TESTING
//   1. Reset, then config ch0 div=4 phase=0, enable=1:
//      - apply on handshake+1;
//      - ce_o[0] pulses every 4 cycles, first 1 cycle after apply;
//      - other channels stay 0.
//   2. ch0 div=4 phase=0 and ch1 div=4 phase=2:
//      - ch1 pulses exactly 2 cycles after each ch0 pulse;
//      - phase_err = 0.
//   3. ch0 running div=8; write div=3 mid-period (cnt=2):
//      - remaining 5 cycles of old period complete;
//      - then pulses every 3 cycles;
//      - cfg_ready low from handshake until apply.
//   4. Drop enable for 5 cycles mid-period:
//      - ce_o = 0 and counters frozen;
//      - on re-enable, next pulse is exactly 5 cycles later than unpaused.
//   5. Config div=4 phase=6:
//      - phase_err[ch] = 1, no strobes;
//      - rewrite phase=1: phase_err clears at apply, strobes resume.
//   6. Assert reset with a pending config and cnt != 0:
//      - next cycle all ce_o = 0, cfg_ready = 1;
//      - pending config never applied.

Source files
------------

// File: rtl/ce_scheduler_if.sv
// Configuration port of ce_scheduler: one {ch, div, phase} request per valid/ready transfer.
// Ports: cfg_valid/cfg_ready handshake, cfg_ch target channel, cfg_div period, cfg_phase offset.
// master drives the request, slave (the scheduler) returns cfg_ready.
interface ce_scheduler_if #(
  parameter int N_CH = 4,
  parameter int W    = 16
);
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]   cfg_div;
  logic [W-1:0]   cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/ce_scheduler.sv
// Purpose: N_CH programmable clock-enable strobes (period div, offset phase) on a single clock.
// Latency: config applies at the target's period boundary (next edge if disabled); first strobe phase+1 edges after apply.
// Backpressure: single pending slot, cfg_ready low from capture until the apply edge.
// Ports: i_clk, i_reset (sync, high), i_enable (global run/freeze), cfg (slave config handshake),
//        o_ce (registered one-cycle strobes), o_phase_err (sticky phase >= div flag per channel).
module ce_scheduler #(
  parameter int N_CH = 4,
  parameter int W    = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  ce_scheduler_if.slave    cfg,
  output logic [N_CH-1:0]  o_ce,
  output logic [N_CH-1:0]  o_phase_err
);
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [W-1:0]   r_div   [N_CH];
  logic [W-1:0]   r_phase [N_CH];
  logic [W-1:0]   r_cnt   [N_CH];

  logic           r_pend_v;
  logic [CHW-1:0] r_pend_ch;
  logic [W-1:0]   r_pend_div;
  logic [W-1:0]   r_pend_phase;

  logic [W-1:0]   w_tgt_div;
  logic [W-1:0]   w_tgt_cnt;
  logic           w_accept;
  logic           w_apply;

  assign cfg.cfg_ready = !r_pend_v;
  assign w_accept      = cfg.cfg_valid && !r_pend_v;

  // Look up the pending target by comparison rather than indexing, so a channel
  // number beyond N_CH reads as a disabled channel: it applies at once and writes nothing.
  always_comb begin
    w_tgt_div = '0;
    w_tgt_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (CHW'(i) == r_pend_ch) begin
        w_tgt_div = r_div[i];
        w_tgt_cnt = r_cnt[i];
      end
    end
  end

  // A disabled target takes the new setting immediately (even with enable low);
  // a running one waits for the last cycle of its period so no strobe is cut or doubled.
  assign w_apply = r_pend_v &&
                   ((w_tgt_div == '0) ||
                    (i_enable && (w_tgt_cnt == w_tgt_div - W'(1))));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_v     <= 1'b0;
      r_pend_ch    <= '0;
      r_pend_div   <= '0;
      r_pend_phase <= '0;
      o_ce         <= '0;
      o_phase_err  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_div[i]   <= '0;
        r_phase[i] <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      // Accept and apply never coincide: accept needs an empty slot, apply a full one.
      if (w_apply) begin
        r_pend_v <= 1'b0;
      end else if (w_accept) begin
        r_pend_v     <= 1'b1;
        r_pend_ch    <= cfg.cfg_ch;
        r_pend_div   <= cfg.cfg_div;
        r_pend_phase <= cfg.cfg_phase;
      end

      for (int i = 0; i < N_CH; i++) begin
        // Strobe uses the pre-edge settings, so the apply edge still belongs to the old period.
        o_ce[i] <= i_enable && (r_div[i] != '0) && (r_cnt[i] == r_phase[i]);

        if (w_apply && (CHW'(i) == r_pend_ch)) begin
          r_div[i]       <= r_pend_div;
          r_phase[i]     <= r_pend_phase;
          r_cnt[i]       <= '0;
          o_phase_err[i] <= (r_pend_div != '0) && (r_pend_phase >= r_pend_div);
        end else if (i_enable && (r_div[i] != '0)) begin
          r_cnt[i] <= (r_cnt[i] == r_div[i] - W'(1)) ? '0 : r_cnt[i] + W'(1);
        end
      end
    end
  end
endmodule
